dm_arbiter: RTL and testbench
=============================

Name: dm_arbiter

Overview:
- Sequences and shares the single-ported data memory (word-addressed RAM with per-byte write enables, active-low write strobe DMld) between two requesters.
- Port A is the pipeline MEM stage; port B is the loader/debug port.
- Performs byte-lane steering for stores, alignment checking, and sign/zero extension for loads.
- Returns load data registered, one cycle after grant.

Parameters:
- B_MAX_WAIT, 4: consecutive cycles B may be denied before B takes priority over A (1..15).
- WAIT_W, 4: width of the B starvation counter.

Ports:
- Clk  input  1  clock; all state on rising edge
- Reset  input  1  asynchronous, active-low reset (0 = reset)
- A_req  input  1  port A request; hold with fields stable until A_gnt=1
- A_we  input  1  1 = store, 0 = load
- A_size  input  2  00 byte, 01 half, 10 word, 11 illegal
- A_sign  input  1  loads: 1 sign-extend, 0 zero-extend
- A_addr  input  32  byte address
- A_wdata  input  32  store data, right-aligned
- A_pc  input  32  PC of the instruction, forwarded to memory for trace
- A_gnt  output  1  combinational grant, same cycle as the accepted request
- A_valid  output  1  registered one-cycle response pulse
- A_err  output  1  with A_valid: misaligned or illegal access
- A_rdata  output  32  extended load data, valid with A_valid
- B_req, B_we, B_size, B_sign, B_addr, B_wdata  inputs  same as A
- B_gnt, B_valid, B_err, B_rdata  outputs  same as A
- Address  output  32  to memory; {18'b0, addr[13:2], 2'b00}
- Wdata  output  32  lane-replicated store data
- DMld  output  1  0 = write this edge, 1 = no write
- BE  output  4  byte enables
- Pc  output  32  A_pc when A granted, 32'h0 for B or idle
- Rdata  input  32  combinational read word from memory

Behaviour:
- Reset low (async): A_valid, B_valid, A_err, B_err = 0; A_rdata, B_rdata = 0; wait counter = 0.
  - During reset both gnt = 0, DMld = 1, BE = 0.
  - The memory's own RAM-clear reset is driven elsewhere, not by this block.
- Idle (no grant): DMld = 1, BE = 0, Address = 0, Wdata = 0, Pc = 0.
- Arbitration, one transaction per cycle, combinational:
  - B wins if B_req and (!A_req or wait == B_MAX_WAIT); otherwise A wins if A_req.
  - At most one gnt is high in a cycle.
- Wait counter:
  - Increments when B_req && !B_gnt, saturating at B_MAX_WAIT.
  - Clears on B_gnt or when B_req = 0.
- Alignment:
  - err = (size==11) | (size==01 & addr[0]) | (size==10 & addr[1:0]!=0).
  - On error: the request is still granted and consumed, but DMld = 1 and BE = 0 (no write).
  - Next cycle: valid = 1, err = 1, rdata = 0.
- Store lanes:
  - Byte: BE = 4'b0001 << addr[1:0]; Wdata = {4{wdata[7:0]}}.
  - Half: BE = addr[1] ? 1100 : 0011; Wdata = {2{wdata[15:0]}}.
  - Word: BE = 1111; Wdata = wdata.
  - DMld = 0 in the grant cycle; the write commits on that rising edge.
- Loads:
  - DMld = 1, BE = 0.
  - On the edge ending the grant cycle, register the selected lane of Rdata (byte at addr[1:0]*8, half at addr[1]*16) and extend per sign.
  - Drive that value as rdata with valid = 1 for exactly the next cycle.
- Stores: valid = 1, err = 0, rdata = 0 on the cycle after grant.
- Response latency is fixed at 1 cycle after gnt for both ports, including back-to-back grants.
- A requester may re-request in the cycle its valid is high.
- Un-granted requesters keep waiting; the arbiter never drops a request.
- Reset asserted mid-transaction: a pending response is lost (valid forced 0). A write already committed on a prior edge stays in memory.

Test Plan:
- A store word: A_addr=0x10, A_wdata=0xDEADBEEF. Expect A_gnt same cycle, DMld=0, BE=1111, Address=0x10. Next cycle A_valid=1, A_err=0. A later A load word at 0x10 returns 0xDEADBEEF.
- Byte/half extension: memory word at 0x20 = 0x80FF7F01.
  - lb 0x23 → 0xFFFFFF80.
  - lbu 0x23 → 0x00000080.
  - lh 0x22 → 0xFFFF80FF.
  - lhu 0x20 → 0x00007F01.
- Store byte at 0x31 with wdata 0x000000AB: BE=0010, Wdata=0xABABABAB. Only bits [15:8] of word 0x30 change.
- Misaligned: lw at 0x42, sh at 0x41, size=11. Each is granted with BE=0 and DMld=1; next cycle err=1 and rdata=0; memory unchanged.
- Contention: A_req and B_req held high continuously with B_MAX_WAIT=4. Grants are A,A,A,A,B, repeating; B_valid follows each B_gnt by 1 cycle; counter returns to 0 after the B grant.
- Reset low asserted in a load grant cycle: valid stays 0, gnt drops immediately. After Reset rises, a fresh request completes normally with 1-cycle latency.

Source files
------------

// File: rtl/dm_arbiter.sv
// Two-port data-memory arbiter with byte-lane steering, alignment checks and load extension.
// B gets priority after B_MAX_WAIT consecutive denials; responses return one cycle after grant.
module dm_arbiter #(
  parameter int B_MAX_WAIT = 4,
  parameter int WAIT_W     = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        A_req,
  input  logic        A_we,
  input  logic [1:0]  A_size,
  input  logic        A_sign,
  input  logic [31:0] A_addr,
  input  logic [31:0] A_wdata,
  input  logic [31:0] A_pc,
  output logic        A_gnt,
  output logic        A_valid,
  output logic        A_err,
  output logic [31:0] A_rdata,
  input  logic        B_req,
  input  logic        B_we,
  input  logic [1:0]  B_size,
  input  logic        B_sign,
  input  logic [31:0] B_addr,
  input  logic [31:0] B_wdata,
  output logic        B_gnt,
  output logic        B_valid,
  output logic        B_err,
  output logic [31:0] B_rdata,
  output logic [31:0] Address,
  output logic [31:0] Wdata,
  output logic        DMld,
  output logic [3:0]  BE,
  output logic [31:0] Pc,
  input  logic [31:0] Rdata
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(B_MAX_WAIT);

  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              a_valid_q, a_valid_d, a_err_q, a_err_d;
  logic              b_valid_q, b_valid_d, b_err_q, b_err_d;
  logic [31:0]       a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;

  logic        a_win, b_win, any_win;
  logic        sel_we, sel_sign, sel_err;
  logic [1:0]  sel_size;
  logic [31:0] sel_addr, sel_wdata, load_ext, byte_word;
  logic [15:0] half_sel;
  logic        unused_addr_hi;

  assign unused_addr_hi = ^sel_addr[31:14];

  // Grants are gated by Reset so nothing reaches memory while reset is held.
  always_comb begin
    b_win   = Reset & B_req & (~A_req | (wait_q == WAIT_MAX));
    a_win   = Reset & A_req & ~b_win;
    any_win = a_win | b_win;
    A_gnt   = a_win;
    B_gnt   = b_win;

    sel_we    = b_win ? B_we    : A_we;
    sel_size  = b_win ? B_size  : A_size;
    sel_sign  = b_win ? B_sign  : A_sign;
    sel_addr  = b_win ? B_addr  : A_addr;
    sel_wdata = b_win ? B_wdata : A_wdata;

    sel_err = (sel_size == 2'b11) |
              ((sel_size == 2'b01) & sel_addr[0]) |
              ((sel_size == 2'b10) & (sel_addr[1:0] != 2'b00));
  end

  always_comb begin
    Address = 32'h0;
    Wdata   = 32'h0;
    DMld    = 1'b1;
    BE      = 4'b0000;
    Pc      = a_win ? A_pc : 32'h0;
    if (any_win) begin
      Address = {18'b0, sel_addr[13:2], 2'b00};
      if (sel_we && !sel_err) begin
        DMld = 1'b0;
        case (sel_size)
          2'b00: begin
            BE    = 4'b0001 << sel_addr[1:0];
            Wdata = {4{sel_wdata[7:0]}};
          end
          2'b01: begin
            BE    = sel_addr[1] ? 4'b1100 : 4'b0011;
            Wdata = {2{sel_wdata[15:0]}};
          end
          default: begin
            BE    = 4'b1111;
            Wdata = sel_wdata;
          end
        endcase
      end
    end
  end

  always_comb begin
    byte_word = Rdata >> {sel_addr[1:0], 3'b000};
    half_sel  = sel_addr[1] ? Rdata[31:16] : Rdata[15:0];
    case (sel_size)
      2'b00:   load_ext = {{24{sel_sign & byte_word[7]}}, byte_word[7:0]};
      2'b01:   load_ext = {{16{sel_sign & half_sel[15]}}, half_sel};
      default: load_ext = Rdata;
    endcase
  end

  always_comb begin
    wait_d = '0;
    if (B_req && !b_win)
      wait_d = (wait_q == WAIT_MAX) ? wait_q : wait_q + WAIT_W'(1);

    a_valid_d = a_win;
    a_err_d   = a_win & sel_err;
    a_rdata_d = (a_win && !sel_we && !sel_err) ? load_ext : 32'h0;
    b_valid_d = b_win;
    b_err_d   = b_win & sel_err;
    b_rdata_d = (b_win && !sel_we && !sel_err) ? load_ext : 32'h0;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      wait_q    <= '0;
      a_valid_q <= 1'b0;
      a_err_q   <= 1'b0;
      a_rdata_q <= 32'h0;
      b_valid_q <= 1'b0;
      b_err_q   <= 1'b0;
      b_rdata_q <= 32'h0;
    end else begin
      wait_q    <= wait_d;
      a_valid_q <= a_valid_d;
      a_err_q   <= a_err_d;
      a_rdata_q <= a_rdata_d;
      b_valid_q <= b_valid_d;
      b_err_q   <= b_err_d;
      b_rdata_q <= b_rdata_d;
    end
  end

  assign A_valid = a_valid_q;
  assign A_err   = a_err_q;
  assign A_rdata = a_rdata_q;
  assign B_valid = b_valid_q;
  assign B_err   = b_err_q;
  assign B_rdata = b_rdata_q;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural byte-enabled word memory.
module tb_dm_arbiter;

  logic        Clk, Reset;
  logic        A_req, A_we, A_sign, B_req, B_we, B_sign;
  logic [1:0]  A_size, B_size;
  logic [31:0] A_addr, A_wdata, A_pc, B_addr, B_wdata;
  logic        A_gnt, A_valid, A_err, B_gnt, B_valid, B_err;
  logic [31:0] A_rdata, B_rdata;
  logic [31:0] Address, Wdata, Pc, Rdata;
  logic        DMld;
  logic [3:0]  BE;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [0:4095];

  dm_arbiter #(.B_MAX_WAIT(4), .WAIT_W(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .A_req(A_req), .A_we(A_we), .A_size(A_size), .A_sign(A_sign),
    .A_addr(A_addr), .A_wdata(A_wdata), .A_pc(A_pc),
    .A_gnt(A_gnt), .A_valid(A_valid), .A_err(A_err), .A_rdata(A_rdata),
    .B_req(B_req), .B_we(B_we), .B_size(B_size), .B_sign(B_sign),
    .B_addr(B_addr), .B_wdata(B_wdata),
    .B_gnt(B_gnt), .B_valid(B_valid), .B_err(B_err), .B_rdata(B_rdata),
    .Address(Address), .Wdata(Wdata), .DMld(DMld), .BE(BE), .Pc(Pc),
    .Rdata(Rdata)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  assign Rdata = mem[Address[13:2]];

  always @(posedge Clk) begin
    if (!DMld) begin
      for (int k = 0; k < 4; k++)
        if (BE[k]) mem[Address[13:2]][8*k +: 8] <= Wdata[8*k +: 8];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Entered one time unit after a rising edge; returns at the same phase one cycle later.
  task automatic op(input bit port_b, input bit we, input logic [1:0] size, input bit sign,
                    input logic [31:0] addr, input logic [31:0] wdata,
                    input bit exp_err, input logic [3:0] exp_be,
                    input logic [31:0] exp_wd, input logic [31:0] exp_rd, input string tag);
    if (port_b) begin
      B_req = 1; B_we = we; B_size = size; B_sign = sign; B_addr = addr; B_wdata = wdata;
    end else begin
      A_req = 1; A_we = we; A_size = size; A_sign = sign; A_addr = addr; A_wdata = wdata;
    end
    #3;
    check({tag, " gnt"}, 32'(port_b ? B_gnt : A_gnt), 32'd1);
    check({tag, " other_gnt"}, 32'(port_b ? A_gnt : B_gnt), 32'd0);
    check({tag, " DMld"}, 32'(DMld), 32'(!(we && !exp_err)));
    check({tag, " BE"}, 32'(BE), 32'(exp_be));
    check({tag, " Wdata"}, Wdata, exp_wd);
    check({tag, " Address"}, Address, {18'b0, addr[13:2], 2'b00});
    check({tag, " Pc"}, Pc, port_b ? 32'h0 : A_pc);
    @(posedge Clk); #1;
    if (port_b) B_req = 0; else A_req = 0;
    check({tag, " valid"}, 32'(port_b ? B_valid : A_valid), 32'd1);
    check({tag, " other_valid"}, 32'(port_b ? A_valid : B_valid), 32'd0);
    check({tag, " err"}, 32'(port_b ? B_err : A_err), 32'(exp_err));
    check({tag, " rdata"}, port_b ? B_rdata : A_rdata, exp_rd);
  endtask

  initial begin
    Reset = 0;
    A_req = 0; A_we = 0; A_size = 0; A_sign = 0; A_addr = 0; A_wdata = 0; A_pc = 32'h0000_0400;
    B_req = 0; B_we = 0; B_size = 0; B_sign = 0; B_addr = 0; B_wdata = 0;

    #2;
    A_req = 1; B_req = 1; A_addr = 32'h10; A_size = 2'b10;
    #1;
    check("rst A_gnt", 32'(A_gnt), 32'd0);
    check("rst B_gnt", 32'(B_gnt), 32'd0);
    check("rst DMld", 32'(DMld), 32'd1);
    check("rst BE", 32'(BE), 32'd0);
    check("rst A_valid", 32'(A_valid), 32'd0);
    check("rst B_valid", 32'(B_valid), 32'd0);
    check("rst A_rdata", A_rdata, 32'h0);
    A_req = 0; B_req = 0;
    @(posedge Clk); #1;
    Reset = 1;
    @(posedge Clk); #1;
    check("idle Address", Address, 32'h0);
    check("idle Wdata", Wdata, 32'h0);
    check("idle DMld", 32'(DMld), 32'd1);
    check("idle Pc", Pc, 32'h0);

    op(0, 1, 2'b10, 0, 32'h10, 32'hDEADBEEF, 0, 4'b1111, 32'hDEADBEEF, 32'h0, "sw10");
    op(0, 0, 2'b10, 0, 32'h10, 32'h0, 0, 4'b0000, 32'h0, 32'hDEADBEEF, "lw10");
    op(1, 1, 2'b10, 0, 32'h20, 32'h80FF7F01, 0, 4'b1111, 32'h80FF7F01, 32'h0, "Bsw20");
    op(0, 0, 2'b00, 1, 32'h23, 32'h0, 0, 4'b0000, 32'h0, 32'hFFFFFF80, "lb23");
    op(0, 0, 2'b00, 0, 32'h23, 32'h0, 0, 4'b0000, 32'h0, 32'h00000080, "lbu23");
    op(0, 0, 2'b01, 1, 32'h22, 32'h0, 0, 4'b0000, 32'h0, 32'hFFFF80FF, "lh22");
    op(0, 0, 2'b01, 0, 32'h20, 32'h0, 0, 4'b0000, 32'h0, 32'h00007F01, "lhu20");
    op(1, 0, 2'b00, 1, 32'h21, 32'h0, 0, 4'b0000, 32'h0, 32'h0000007F, "Blb21");

    op(0, 1, 2'b10, 0, 32'h30, 32'h11223344, 0, 4'b1111, 32'h11223344, 32'h0, "sw30");
    op(0, 1, 2'b00, 0, 32'h31, 32'h000000AB, 0, 4'b0010, 32'hABABABAB, 32'h0, "sb31");
    op(0, 0, 2'b10, 0, 32'h30, 32'h0, 0, 4'b0000, 32'h0, 32'h1122AB44, "lw30a");
    op(0, 1, 2'b01, 0, 32'h32, 32'h00005566, 0, 4'b1100, 32'h55665566, 32'h0, "sh32");
    op(0, 0, 2'b10, 0, 32'h30, 32'h0, 0, 4'b0000, 32'h0, 32'h5566AB44, "lw30b");

    op(0, 1, 2'b10, 0, 32'h40, 32'hCAFEF00D, 0, 4'b1111, 32'hCAFEF00D, 32'h0, "sw40");
    op(0, 0, 2'b10, 0, 32'h42, 32'h0, 1, 4'b0000, 32'h0, 32'h0, "lw42mis");
    op(0, 1, 2'b01, 0, 32'h41, 32'h00001111, 1, 4'b0000, 32'h0, 32'h0, "sh41mis");
    op(1, 1, 2'b11, 0, 32'h40, 32'h22222222, 1, 4'b0000, 32'h0, 32'h0, "Bsz11");
    op(0, 0, 2'b10, 0, 32'h40, 32'h0, 0, 4'b0000, 32'h0, 32'hCAFEF00D, "lw40");

    A_we = 0; A_size = 2'b10; A_addr = 32'h10; A_req = 1;
    B_we = 0; B_size = 2'b10; B_addr = 32'h40; B_req = 1;
    for (int i = 0; i < 10; i++) begin
      #3;
      check($sformatf("cont%0d A_gnt", i), 32'(A_gnt), 32'(i % 5 != 4));
      check($sformatf("cont%0d B_gnt", i), 32'(B_gnt), 32'(i % 5 == 4));
      @(posedge Clk); #1;
      check($sformatf("cont%0d A_valid", i), 32'(A_valid), 32'(i % 5 != 4));
      check($sformatf("cont%0d B_valid", i), 32'(B_valid), 32'(i % 5 == 4));
      if (i % 5 == 4) check($sformatf("cont%0d B_rdata", i), B_rdata, 32'hCAFEF00D);
      else            check($sformatf("cont%0d A_rdata", i), A_rdata, 32'hDEADBEEF);
    end
    A_req = 0; B_req = 0;
    @(posedge Clk); #1;

    A_req = 1; A_we = 0; A_size = 2'b10; A_addr = 32'h10;
    #3;
    check("rstmid gnt", 32'(A_gnt), 32'd1);
    #1;
    Reset = 0;
    #1;
    check("rstmid gnt_drop", 32'(A_gnt), 32'd0);
    check("rstmid DMld", 32'(DMld), 32'd1);
    @(posedge Clk); #1;
    check("rstmid valid", 32'(A_valid), 32'd0);
    A_req = 0;
    Reset = 1;
    @(posedge Clk); #1;
    op(0, 0, 2'b10, 0, 32'h10, 32'h0, 0, 4'b0000, 32'h0, 32'hDEADBEEF, "post_rst");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
